alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_if.sv | 31 +++
 rtl/alu.sv | 59 +++++
 tb/tb_alu.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// alu_if: operation codes and the operand/result bus shared by the ALU and its driver

package alu_pkg;
    localparam logic [3:0] CODE_ALU_EX_SLL  = 4'h0;
    localparam logic [3:0] CODE_ALU_EX_SRL  = 4'h1;
    localparam logic [3:0] CODE_ALU_EX_SRA  = 4'h2;
    localparam logic [3:0] CODE_ALU_EX_ADD  = 4'h3;
    localparam logic [3:0] CODE_ALU_EX_SUB  = 4'h4;
    localparam logic [3:0] CODE_ALU_EX_AND  = 4'h5;
    localparam logic [3:0] CODE_ALU_EX_OR   = 4'h6;
    localparam logic [3:0] CODE_ALU_EX_XOR  = 4'h7;
    localparam logic [3:0] CODE_ALU_EX_NOR  = 4'h8;
    localparam logic [3:0] CODE_ALU_EX_SLT  = 4'h9;
    localparam logic [3:0] CODE_ALU_EX_SLLV = 4'hA;
    localparam logic [3:0] CODE_ALU_EX_SRLV = 4'hB;
    localparam logic [3:0] CODE_ALU_EX_SRAV = 4'hC;
    localparam logic [3:0] CODE_ALU_EX_NOP  = 4'hD;
endpackage

interface alu_if #(
    parameter int IO_BUS_WIDTH  = 32,
    parameter int CTR_BUS_WIDTH = 4
);
    logic [CTR_BUS_WIDTH-1:0] i_ctr_code;
    logic [IO_BUS_WIDTH-1:0]  i_data_a;
    logic [IO_BUS_WIDTH-1:0]  i_data_b;
    logic [IO_BUS_WIDTH-1:0]  o_data;

    modport master (output i_ctr_code, i_data_a, i_data_b, input o_data);
    modport slave  (input i_ctr_code, i_data_a, i_data_b, output o_data);
endinterface

// File: rtl/alu.sv
// alu: single-cycle registered ALU with tri-stated output for NOP and unused codes

module alu
    import alu_pkg::*;
#(
    parameter int IO_BUS_WIDTH  = 32,
    parameter int CTR_BUS_WIDTH = 4
) (
    input  logic  i_clk,
    input  logic  i_reset,
    alu_if.slave  bus
);
    localparam int SHW = $clog2(IO_BUS_WIDTH);

    logic [IO_BUS_WIDTH-1:0] w_a, w_b, w_result;
    logic [SHW-1:0]          w_sh;
    logic                    w_big, w_hiz;
    logic [IO_BUS_WIDTH-1:0] r_data;
    logic                    r_hiz;

    assign w_a   = bus.i_data_a;
    assign w_b   = bus.i_data_b;
    assign w_sh  = w_b[SHW-1:0];
    // Any shift amount at or beyond the width saturates instead of wrapping
    assign w_big = w_b >= IO_BUS_WIDTH;

    // Result and drive-enable for the operation presented this cycle
    always_comb begin
        w_result = '0;
        w_hiz    = 1'b0;
        case (bus.i_ctr_code)
            CODE_ALU_EX_SLL, CODE_ALU_EX_SLLV: w_result = w_big ? '0 : w_a << w_sh;
            CODE_ALU_EX_SRL, CODE_ALU_EX_SRLV: w_result = w_big ? '0 : w_a >> w_sh;
            CODE_ALU_EX_SRA, CODE_ALU_EX_SRAV: w_result = w_big ? {IO_BUS_WIDTH{w_a[IO_BUS_WIDTH-1]}}
                                                                : $unsigned($signed(w_a) >>> w_sh);
            CODE_ALU_EX_ADD: w_result = w_a + w_b;
            CODE_ALU_EX_SUB: w_result = w_a - w_b;
            CODE_ALU_EX_AND: w_result = w_a & w_b;
            CODE_ALU_EX_OR:  w_result = w_a | w_b;
            CODE_ALU_EX_XOR: w_result = w_a ^ w_b;
            CODE_ALU_EX_NOR: w_result = ~(w_a | w_b);
            CODE_ALU_EX_SLT: w_result = {{(IO_BUS_WIDTH-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            default:         w_hiz    = 1'b1;
        endcase
    end

    // Register the result; reset forces a driven zero and drops any in-flight result
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_data <= '0;
            r_hiz  <= 1'b0;
        end else begin
            r_data <= w_result;
            r_hiz  <= w_hiz;
        end
    end

    assign bus.o_data = r_hiz ? {IO_BUS_WIDTH{1'bz}} : r_data;
endmodule

// File: tb/tb_alu.sv
// tb_alu: table-driven scoreboard bench for alu
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          hiz;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        bit          hiz;
        string       name;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    vec_t vecs[$];
    sb_t  sb[$];

    alu_if bus ();
    alu dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input bit hiz);
        logic [31:0] want;
        want = hiz ? 32'hzzzz_zzzz : exp;
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic drive(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.i_ctr_code = code;
        bus.i_data_a   = a;
        bus.i_data_b   = b;
    endtask

    task automatic issue(input vec_t v);
        sb_t e;
        drive(v.code, v.a, v.b);
        sb.push_back('{v.exp, v.hiz, v.name});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty %s", v.name);
        end else begin
            e = sb.pop_front();
            check(e.name, bus.o_data, e.exp, e.hiz);
        end
    endtask

    task automatic add(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input bit z, input string n);
        vecs.push_back('{c, a, b, e, z, n});
    endtask

    initial begin
        add(CODE_ALU_EX_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, "add_wrap");
        add(CODE_ALU_EX_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, "sub_wrap");
        add(CODE_ALU_EX_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, "and");
        add(CODE_ALU_EX_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, "or");
        add(CODE_ALU_EX_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, "xor");
        add(CODE_ALU_EX_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 0, "nor");
        add(CODE_ALU_EX_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, "slt_neg_lt_pos");
        add(CODE_ALU_EX_SLT, 32'h1, 32'hFFFF_FFFF, 32'h0, 0, "slt_pos_vs_neg");
        add(CODE_ALU_EX_SLT, 32'h5, 32'h5, 32'h0, 0, "slt_equal");
        add(CODE_ALU_EX_SLL,  32'h8000_0001, 32'd4, 32'h0000_0010, 0, "sll_4");
        add(CODE_ALU_EX_SRL,  32'h8000_0001, 32'd4, 32'h0800_0000, 0, "srl_4");
        add(CODE_ALU_EX_SRA,  32'h8000_0001, 32'd4, 32'hF800_0000, 0, "sra_4");
        add(CODE_ALU_EX_SLLV, 32'h8000_0001, 32'd4, 32'h0000_0010, 0, "sllv_4");
        add(CODE_ALU_EX_SRLV, 32'h8000_0001, 32'd4, 32'h0800_0000, 0, "srlv_4");
        add(CODE_ALU_EX_SRAV, 32'h8000_0001, 32'd4, 32'hF800_0000, 0, "srav_4");
        add(CODE_ALU_EX_SLL,  32'h8000_0001, 32'd40, 32'h0, 0, "sll_40");
        add(CODE_ALU_EX_SRL,  32'h8000_0001, 32'd40, 32'h0, 0, "srl_40");
        add(CODE_ALU_EX_SRA,  32'h8000_0001, 32'd40, 32'hFFFF_FFFF, 0, "sra_40");
        add(CODE_ALU_EX_SLLV, 32'h8000_0001, 32'd40, 32'h0, 0, "sllv_40");
        add(CODE_ALU_EX_SRLV, 32'h8000_0001, 32'd40, 32'h0, 0, "srlv_40");
        add(CODE_ALU_EX_SRAV, 32'h8000_0001, 32'd40, 32'hFFFF_FFFF, 0, "srav_40");
        add(CODE_ALU_EX_SRL,  32'h8000_0001, 32'd31, 32'h1, 0, "srl_31");
        add(CODE_ALU_EX_SRL,  32'h8000_0001, 32'd32, 32'h0, 0, "srl_32");
        add(CODE_ALU_EX_SLL,  32'h0000_0001, 32'h8000_0000, 32'h0, 0, "sll_huge");
        add(CODE_ALU_EX_SRA,  32'h4000_0000, 32'd100, 32'h0, 0, "sra_pos_100");
        add(CODE_ALU_EX_SRA,  32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 0, "sra_31");
        add(CODE_ALU_EX_NOP,  32'h1, 32'h2, 32'h0, 1, "nop_d");
        add(4'hE, 32'h1, 32'h2, 32'h0, 1, "nop_e");
        add(4'hF, 32'h1, 32'h2, 32'h0, 1, "nop_f");
        add(CODE_ALU_EX_ADD, 32'd2, 32'd3, 32'd5, 0, "add_after_nop");

        bus.i_ctr_code = CODE_ALU_EX_ADD;
        bus.i_data_a   = 32'd9;
        bus.i_data_b   = 32'd9;
        #1;
        check("reset_async", bus.o_data, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", bus.o_data, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) issue(vecs[i]);

        // Reset asserted between edges while o_data holds 5
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_mid_cycle", bus.o_data, 32'h0, 0);
        drive(CODE_ALU_EX_ADD, 32'd7, 32'd7);
        @(posedge clk);
        #1;
        check("reset_discard_edge1", bus.o_data, 32'h0, 0);
        @(posedge clk);
        #1;
        check("reset_discard_edge2", bus.o_data, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue('{CODE_ALU_EX_ADD, 32'd1, 32'd1, 32'd2, 0, "add_after_reset"});

        // Reset cancels a NOP tri-state immediately
        issue('{CODE_ALU_EX_NOP, 32'd0, 32'd0, 32'h0, 1, "nop_before_reset"});
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_over_nop", bus.o_data, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue('{CODE_ALU_EX_SUB, 32'd10, 32'd3, 32'd7, 0, "sub_after_reset"});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
